io_button_reader: RTL and testbench



---
 rtl/io_button_reader.sv | 139 +++++++++++++
 tb/tb_io_button_reader.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/io_button_reader.sv
// Memory-mapped push-button reader: 2-flop sync, per-button debounce, sticky
// press flags with W1C, 16-bit press counter, maskable irq, registered reads.

module io_button_debounce #(
   parameter int DB_CYCLES = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic level,
   output logic rise
);
   localparam int CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

   logic [1:0]    sync_q;
   logic [CW-1:0] cnt_q;
   logic          level_q;
   logic          flip;

   // flip fires on the cycle the counter has seen DB_CYCLES disagreeing samples
   assign flip  = (sync_q[1] != level_q) && (cnt_q == LAST);
   assign rise  = flip && sync_q[1];
   assign level = level_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q  <= '0;
         cnt_q   <= '0;
         level_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], btn};
         if (sync_q[1] == level_q) begin
            cnt_q <= '0;
         end else if (flip) begin
            cnt_q   <= '0;
            level_q <= sync_q[1];
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end
endmodule

module io_button_reader #(
   parameter int             WIDTH     = 32,
   parameter logic [31:0]    BASE      = 32'h0000FF10,
   parameter int             NBTN      = 4,
   parameter int             DB_CYCLES = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] adr,
   input  logic             memread,
   input  logic             memwrite,
   input  logic [WIDTH-1:0] writedata,
   input  logic [NBTN-1:0]  btn,
   output logic [WIDTH-1:0] io_rdata,
   output logic             irq
);
   localparam logic [WIDTH-1:0] BASE_W = WIDTH'(BASE);

   logic [NBTN-1:0]  level;
   logic [NBTN-1:0]  rise;
   logic [NBTN-1:0]  event_q;
   logic [NBTN-1:0]  mask_q;
   logic             en_q;
   logic [15:0]      count_q;
   logic             hit;
   logic [1:0]       off;
   logic             wr_event;
   logic             wr_ctrl;
   logic [NBTN-1:0]  w1c;
   logic [NBTN-1:0]  set_ev;
   logic [WIDTH-1:0] rd_mux;
   logic             unused_ok;

   genvar gi;
   generate
      for (gi = 0; gi < NBTN; gi++) begin : g_btn
         io_button_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
            .clk   (clk),
            .reset (reset),
            .btn   (btn[gi]),
            .level (level[gi]),
            .rise  (rise[gi])
         );
      end
   endgenerate

   function automatic logic [15:0] popcnt(input logic [NBTN-1:0] v);
      logic [15:0] n;
      n = '0;
      for (int i = 0; i < NBTN; i++) n = n + 16'(v[i]);
      return n;
   endfunction

   assign hit      = (adr[WIDTH-1:4] == BASE_W[WIDTH-1:4]);
   assign off      = adr[3:2];
   assign wr_event = memwrite && hit && (off == 2'd1);
   assign wr_ctrl  = memwrite && hit && (off == 2'd3);
   assign w1c      = wr_event ? writedata[NBTN-1:0] : '0;
   assign set_ev   = en_q ? rise : '0;
   assign unused_ok = &{1'b0, adr[1:0], writedata};

   always_comb begin
      rd_mux = '0;
      case (off)
         2'd0: rd_mux[NBTN-1:0] = level;
         2'd1: rd_mux[NBTN-1:0] = event_q;
         2'd2: rd_mux[15:0]     = count_q;
         default: begin
            rd_mux[NBTN-1:0] = mask_q;
            rd_mux[8]        = en_q;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         event_q  <= '0;
         mask_q   <= '0;
         en_q     <= 1'b1;
         count_q  <= '0;
         irq      <= 1'b0;
         io_rdata <= '0;
      end else begin
         // a press landing with its own W1C keeps the flag set
         event_q  <= (event_q & ~w1c) | set_ev;
         count_q  <= count_q + popcnt(set_ev);
         irq      <= |(event_q & mask_q);
         io_rdata <= (memread && hit) ? rd_mux : '0;
         if (wr_ctrl) begin
            mask_q <= writedata[NBTN-1:0];
            en_q   <= writedata[8];
         end
      end
   end
endmodule

// File: tb/tb_io_button_reader.sv
// Bench for io_button_reader: window-based behavioural model checked every
// cycle, plus directed reads with literal expectations.

module tb_io_button_reader;
   localparam int          NBTN = 4;
   localparam int          DB   = 16;
   localparam logic [31:0] BASE = 32'h0000FF10;
   localparam logic [31:0] A_LVL = BASE, A_EVT = BASE + 4, A_CNT = BASE + 8, A_CTL = BASE + 12;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic [31:0]     adr = '0;
   logic            memread = 1'b0;
   logic            memwrite = 1'b0;
   logic [31:0]     writedata = '0;
   logic [NBTN-1:0] btn = '0;
   logic [31:0]     io_rdata;
   logic            irq;

   int checks = 0;
   int errors = 0;
   logic started = 1'b0;
   logic preload = 1'b0;

   io_button_reader #(.WIDTH(32), .BASE(BASE), .NBTN(NBTN), .DB_CYCLES(DB)) dut (
      .clk(clk), .reset(reset), .adr(adr), .memread(memread), .memwrite(memwrite),
      .writedata(writedata), .btn(btn), .io_rdata(io_rdata), .irq(irq)
   );

   always #5 clk = ~clk;

   // model: hist[k] is the raw button sample from k+1 edges ago; a level flips
   // once the 2-cycle-delayed view has disagreed with it for DB straight samples
   logic [NBTN-1:0] hist [0:DB];
   logic [NBTN-1:0] m_lvl, m_event, m_mask;
   logic            m_en, m_irq;
   logic [15:0]     m_count;
   logic [31:0]     m_rdata;

   function automatic logic [NBTN-1:0] m_flips();
      logic [NBTN-1:0] f;
      f = '1;
      for (int i = 0; i < NBTN; i++)
         for (int k = 1; k <= DB; k++)
            if (hist[k][i] == m_lvl[i]) f[i] = 1'b0;
      return f;
   endfunction

   function automatic logic in_win();
      return (adr >= BASE) && (adr <= BASE + 32'd15);
   endfunction

   function automatic logic [31:0] m_read();
      logic [31:0] r;
      r = '0;
      if (memread && in_win()) begin
         case ((adr - BASE) >> 2)
            0: r = {28'd0, m_lvl};
            1: r = {28'd0, m_event};
            2: r = {16'd0, m_count};
            default: r = (m_en ? 32'h100 : 32'h0) | {28'd0, m_mask};
         endcase
      end
      return r;
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k <= DB; k++) hist[k] <= '0;
         m_lvl <= '0; m_event <= '0; m_mask <= '0; m_en <= 1'b1;
         m_irq <= 1'b0; m_count <= '0; m_rdata <= '0;
      end else begin
         m_rdata <= m_read();
         m_irq   <= |(m_event & m_mask);
         m_lvl   <= m_lvl ^ m_flips();
         m_event <= (m_event & ~((memwrite && in_win() && (adr - BASE) >> 2 == 1) ? writedata[NBTN-1:0] : '0))
                    | (m_en ? (m_flips() & ~m_lvl) : '0);
         m_count <= preload ? 16'hFFFF
                    : m_count + (m_en ? 16'($countones(m_flips() & ~m_lvl)) : 16'd0);
         if (memwrite && in_win() && (adr - BASE) >> 2 == 3) begin
            m_mask <= writedata[NBTN-1:0];
            m_en   <= writedata[8];
         end
         hist[0] <= btn;
         for (int k = 1; k <= DB; k++) hist[k] <= hist[k-1];
      end
   end

   always @(negedge clk) begin
      if (started) begin
         checks++;
         if (io_rdata !== m_rdata) begin
            errors++;
            $display("FAIL model_rdata t=%0t got=%h exp=%h", $time, io_rdata, m_rdata);
         end
         checks++;
         if (irq !== m_irq) begin
            errors++;
            $display("FAIL model_irq t=%0t got=%b exp=%b", $time, irq, m_irq);
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", nm, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string nm);
      adr = a; memread = 1'b1;
      tick(1);
      chk(nm, io_rdata, exp);
      memread = 1'b0; adr = '0;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      adr = a; writedata = d; memwrite = 1'b1;
      tick(1);
      memwrite = 1'b0; adr = '0; writedata = '0;
   endtask

   initial begin
      tick(3);
      chk("rst_rdata", io_rdata, 32'h0);
      chk("rst_irq", {31'd0, irq}, 32'h0);
      reset = 1'b0;
      started = 1'b1;
      rd(A_CTL, 32'h100, "rst_ctrl");
      rd(A_LVL, 32'h0, "rst_level");
      rd(A_EVT, 32'h0, "rst_event");
      rd(A_CNT, 32'h0, "rst_count");

      // btn0 press: level visible internally after 18 edges, read data one later
      btn[0] = 1'b1; adr = A_LVL; memread = 1'b1;
      tick(18);
      chk("lat18_before", io_rdata, 32'h0);
      tick(1);
      chk("lat18_after", io_rdata, 32'h1);
      memread = 1'b0; adr = '0;
      rd(A_EVT, 32'h1, "press0_event");
      rd(A_CNT, 32'h1, "press0_count");
      wr(A_EVT, 32'h1);
      rd(A_EVT, 32'h0, "w1c_event");
      rd(BASE - 32'd4, 32'h0, "below_window");
      rd(BASE + 32'h10, 32'h0, "above_window");

      // 10-cycle glitch on btn2
      btn[2] = 1'b1; tick(10); btn[2] = 1'b0; tick(30);
      rd(A_LVL, 32'h1, "glitch_level");
      rd(A_EVT, 32'h0, "glitch_event");
      rd(A_CNT, 32'h1, "glitch_count");

      // simultaneous rise of btn1/btn3 with masks enabled
      wr(A_CTL, 32'h10F);
      wr(BASE + 32'h1C, 32'h0);
      rd(A_CTL, 32'h10F, "ctrl_rw");
      btn[1] = 1'b1; btn[3] = 1'b1;
      tick(18);
      chk("irq_before", {31'd0, irq}, 32'h0);
      tick(1);
      chk("irq_after", {31'd0, irq}, 32'h1);
      rd(A_EVT, 32'hA, "dual_event");
      rd(A_CNT, 32'h3, "dual_count");
      wr(A_EVT, 32'h2); tick(1);
      chk("irq_w1c2", {31'd0, irq}, 32'h1);
      wr(A_EVT, 32'h8); tick(1);
      chk("irq_w1c8", {31'd0, irq}, 32'h0);

      // counter wrap, and W1C colliding with a new btn0 press
      btn[0] = 1'b0; tick(20);
      force dut.count_q = 16'hFFFF;
      preload = 1'b1;
      tick(1);
      preload = 1'b0;
      release dut.count_q;
      rd(A_CNT, 32'hFFFF, "preload_count");
      btn[0] = 1'b1;
      tick(17);
      adr = A_EVT; writedata = 32'h1; memwrite = 1'b1;
      tick(1);
      memwrite = 1'b0; adr = '0; writedata = '0;
      rd(A_EVT, 32'h1, "set_beats_w1c");
      rd(A_CNT, 32'h0, "count_wrap");

      // EN=0: levels track, no events
      wr(A_CTL, 32'h000);
      wr(A_EVT, 32'h1);
      btn[0] = 1'b0; tick(20);
      btn[0] = 1'b1; tick(20);
      rd(A_LVL, 32'hB, "dis_level");
      rd(A_EVT, 32'h0, "dis_event");
      rd(A_CNT, 32'h0, "dis_count");

      // reset mid-read and mid-debounce of btn1
      btn[1] = 1'b0; tick(20);
      btn[1] = 1'b1; tick(8);
      adr = A_LVL; memread = 1'b1;
      tick(1);
      chk("pre_reset_read", io_rdata, 32'h9);
      reset = 1'b1;
      #1;
      chk("async_rdata", io_rdata, 32'h0);
      memread = 1'b0; adr = '0;
      tick(2);
      reset = 1'b0;
      rd(A_CTL, 32'h100, "rst2_ctrl");
      rd(A_LVL, 32'h0, "rst2_level");
      rd(A_EVT, 32'h0, "rst2_event");
      rd(A_CNT, 32'h0, "rst2_count");
      tick(25);
      rd(A_LVL, 32'hB, "held_level");
      rd(A_EVT, 32'hB, "held_event");
      rd(A_CNT, 32'h3, "held_count");

      tick(2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
